imem_loader: RTL and testbench

- Serial-to-word writer that fills the instruction memory before the MIPS pipeline runs.
- Accepts a byte stream and assembles big-endian 32-bit instructions. Drives the memory's word write port at consecutive word addresses.
- Holds the CPU in reset until the image is completely written.
- Sits between the host byte receiver and the instruction memory's write side. The pipeline's fetch path stays a pure reader.

---
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader that assembles big-endian words into instruction memory and holds the CPU in reset until done.
// Optional trailing checksum byte when IMEM_LOADER_CKSUM_EN is defined.
module imem_loader #(
    parameter int          MEM_SIZE  = 512,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_WORD, S_WRITE, S_DONE, S_ERROR
`ifdef IMEM_LOADER_CKSUM_EN
        , S_CKSUM
`endif
    } state_t;

`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_t S_END = S_CKSUM;
`else
    localparam state_t S_END = S_DONE;
`endif

    localparam logic [16:0] MAX_N = 17'(MEM_SIZE);

    state_t      state, next;
    logic [7:0]  len_hi;
    logic [15:0] n;
    logic [1:0]  byte_idx;
    logic [31:0] asm_word;
    logic [15:0] n_in;
    logic [15:0] wc_inc;
    logic        xfer;
    logic        idle_like;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]  cksum;
`endif

    assign n_in        = {len_hi, rx_data};
    assign wc_inc      = word_count + 16'd1;
    assign xfer        = rx_valid && rx_ready;
    assign idle_like   = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
    assign mem_wr_addr = ADDR_BASE + {14'd0, word_count, 2'b00};
    assign mem_wr_data = asm_word;

    always_comb begin
        next      = state;
        rx_ready  = 1'b0;
        mem_wr_en = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) next = S_LEN_HI;
            S_LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) next = S_LEN_LO;
            end
            S_LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (n_in == 16'd0)              next = S_END;
                    else if ({1'b0, n_in} > MAX_N)  next = S_ERROR;
                    else                            next = S_WORD;
                end
            end
            S_WORD: begin
                rx_ready = 1'b1;
                if (rx_valid && byte_idx == 2'd3) next = S_WRITE;
            end
            S_WRITE: begin
                mem_wr_en = 1'b1;
                next      = (wc_inc == n) ? S_END : S_WORD;
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_CKSUM: begin
                rx_ready = 1'b1;
                // Checksum byte itself is not folded into the running XOR.
                if (rx_valid) next = (cksum == rx_data) ? S_DONE : S_ERROR;
            end
`endif
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            len_hi     <= 8'd0;
            n          <= 16'd0;
            byte_idx   <= 2'd0;
            asm_word   <= 32'd0;
            word_count <= 16'd0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum      <= 8'd0;
`endif
        end else begin
            state      <= next;
            cpu_hold   <= (next != S_DONE);
            load_done  <= (next == S_DONE);
            load_error <= (next == S_ERROR);
            if (idle_like && start) begin
                word_count <= 16'd0;
                byte_idx   <= 2'd0;
`ifdef IMEM_LOADER_CKSUM_EN
                cksum      <= 8'd0;
`endif
            end
`ifdef IMEM_LOADER_CKSUM_EN
            if (xfer && state != S_CKSUM) cksum <= cksum ^ rx_data;
`endif
            case (state)
                S_LEN_HI: if (xfer) len_hi <= rx_data;
                S_LEN_LO: if (xfer) begin
                    n        <= n_in;
                    byte_idx <= 2'd0;
                end
                S_WORD: if (xfer) begin
                    asm_word <= {asm_word[23:0], rx_data};
                    byte_idx <= byte_idx + 2'd1;
                end
                S_WRITE: if (word_count != n) word_count <= wc_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed images plus random images against a stream-level model.
module tb_imem_loader;
    localparam int          MEM_SIZE  = 512;
    localparam logic [31:0] ADDR_BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, mem_wr_en, cpu_hold, load_done, load_error;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic [15:0] word_count;

    imem_loader #(.MEM_SIZE(MEM_SIZE), .ADDR_BASE(ADDR_BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_error(load_error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    int          b2b = 0;
    logic        prev_we = 1'b0;
    logic [31:0] got_addr[$], got_data[$];
    logic [31:0] img[$];

    // Write-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            got_addr.push_back(mem_wr_addr);
            got_data.push_back(mem_wr_data);
            if (prev_we) b2b++;
        end
        prev_we = (mem_wr_en === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps);
        int   cyc;
        logic rdy;
        for (int g = 0; g < gaps; g++) begin
            rx_valid = 1'b0;
            @(negedge clk);
            check("gap_ready", rx_ready, 1);
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        cyc = 0;
        rdy = 1'b0;
        while (!rdy && cyc < 20) begin
            @(negedge clk);
            rdy = rx_ready;
            @(posedge clk); #1;
            cyc++;
        end
        rx_valid = 1'b0;
        check("byte_accepted", rdy, 1);
    endtask

    // Loads an image of n words (from img, topped up randomly) and checks the outcome.
    task automatic run_image(input int n, input bit gapped, input bit bad_ck);
        logic [7:0]  q[$];
        logic [15:0] nn;
        logic [31:0] w;
        logic [7:0]  x;
        int          waited, exp_wait, nexp;
        bit          legal, ok;
        nn    = 16'(n);
        legal = (n <= MEM_SIZE);
        ok    = legal && !bad_ck;
        while (img.size() < n && legal) img.push_back($urandom);
        q.push_back(nn[15:8]);
        q.push_back(nn[7:0]);
        if (legal)
            for (int i = 0; i < n; i++) begin
                w = img[i];
                q.push_back(w[31:24]); q.push_back(w[23:16]);
                q.push_back(w[15:8]);  q.push_back(w[7:0]);
            end
        x = 8'd0;
        foreach (q[i]) x ^= q[i];
`ifdef IMEM_LOADER_CKSUM_EN
        if (legal) q.push_back(bad_ck ? (x ^ 8'h01) : x);
        exp_wait = 0;
`else
        exp_wait = (legal && n != 0) ? 1 : 0;
`endif
        got_addr.delete();
        got_data.delete();
        pulse_start();
        check("start_hold", cpu_hold, 1);
        check("start_done_clr", load_done, 0);
        check("start_err_clr", load_error, 0);
        foreach (q[k])
            send_byte(q[k], (gapped && k > 0 && !(k >= 2 && (k - 2) % 4 == 0)) ? 2 : 0);
        waited = 0;
        while (!(load_done || load_error) && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        nexp = legal ? n : 0;
        check("end_latency", waited, exp_wait);
        check("load_done", load_done, ok);
        check("load_error", load_error, !ok);
        check("cpu_hold", cpu_hold, !ok);
        check("end_rx_ready", rx_ready, 0);
        check("word_count", word_count, nexp);
        check("num_writes", got_addr.size(), nexp);
        for (int i = 0; i < nexp && i < got_addr.size(); i++) begin
            check("wr_addr", got_addr[i], ADDR_BASE + 32'(4 * i));
            check("wr_data", got_data[i], img[i]);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #1;
        check("rst_rx_ready", rx_ready, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", mem_wr_addr, ADDR_BASE);
        check("rst_data", mem_wr_data, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", load_done, 0);
        check("rst_err", load_error, 0);
        check("rst_wc", word_count, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        img = '{32'h20040005, 32'h00001026, 32'h0C000004};
        run_image(3, 0, 0);

        img.delete();
        run_image(0, 0, 0);

        run_image(513, 0, 0);
        rx_valid = 1'b1; rx_data = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            check("err_rx_ready", rx_ready, 0);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check("err_no_writes", got_addr.size(), 0);
        check("err_stays", load_error, 1);

        img.delete();
        run_image(1, 1, 0);

        // Abort mid-word, then reload from scratch.
        got_addr.delete();
        got_data.delete();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_ignored_ready", rx_ready, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready", rx_ready, 0);
        check("mid_rst_wr_en", mem_wr_en, 0);
        check("mid_rst_addr", mem_wr_addr, ADDR_BASE);
        check("mid_rst_data", mem_wr_data, 0);
        check("mid_rst_hold", cpu_hold, 1);
        check("mid_rst_wc", word_count, 0);
        check("mid_rst_writes", got_addr.size(), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        img.delete();
        run_image(3, 0, 0);

        for (int r = 0; r < 4; r++) begin
            img.delete();
            run_image($urandom_range(8, 1), 1'($urandom_range(1, 0)), 0);
        end

        img.delete();
        run_image(MEM_SIZE, 0, 0);

`ifdef IMEM_LOADER_CKSUM_EN
        img = '{32'h12345678};
        run_image(1, 0, 0);
        run_image(1, 0, 1);
`endif

        check("no_back_to_back_writes", b2b, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
